// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for an RV32 lw/sw/beq datapath.
// Sequences fetch, decode, address/branch ALU work, memory access and
// writeback. It drives the shared ALU selects, the IR/PC enables and a
// single req/ready memory port.
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   opcode             IR[6:0] of the latched instruction
//   zero               ALU zero flag (branch compare)
//   mem_ready          memory completes the current access this cycle
//   mem_req/mem_we     memory request / write strobe
//   iord               address select: 0 = PC, 1 = ALU result register
//   ir_write/pc_write  IR and PC load enables; pc_src selects the PC source
//   alu_src_a/b,alu_op ALU operand and operation selects
//   reg_write          register file write enable
//   mem_to_reg         writeback data comes from the memory data register
//   illegal, bus_err   sticky error flags
//   retired            wrapping count of completed instructions
//
// Optional build macro MEM_TIMEOUT_EN: adds a memory wait counter. When a
// request sees no mem_ready for MEM_TIMEOUT cycles, the FSM traps and sets
// bus_err. Without the macro, accesses wait forever and bus_err is 0.
module unidade_controle_multiciclo #(
  parameter int MEM_TIMEOUT = 15,
  parameter int RET_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [RET_WIDTH-1:0] retired
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC_ADDR, MEM_RD, WB, MEM_WR, BRANCH, TRAP
  } state_t;

  state_t               state_q, state_d;
  logic [RET_WIDTH-1:0] retired_q, retired_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout;
  logic                 req_raw, irw_raw, pcw_raw, rw_raw;

`ifdef MEM_TIMEOUT_EN
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  logic [WW-1:0] wait_q, wait_d;
  logic          bus_err_q, bus_err_d;

  // The wait that would make the count reach MEM_TIMEOUT is terminal.
  // A mem_ready in that same cycle still completes the access.
  assign timeout = req_raw && !mem_ready && (wait_q == WW'(MEM_TIMEOUT - 1));

  always_comb begin
    wait_d    = '0;
    bus_err_d = bus_err_q | timeout;
    // The count restarts on every entry to a request state, so a new
    // access never inherits the cycles of the previous one.
    if (req_raw && state_d == state_q && !mem_ready)
      wait_d = wait_q + WW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    retired_d  = retired_q;
    illegal_d  = illegal_q;
    req_raw    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    irw_raw    = 1'b0;
    pcw_raw    = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    rw_raw     = 1'b0;
    mem_to_reg = 1'b0;
    unique case (state_q)
      FETCH: begin
        req_raw   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          irw_raw = 1'b1;
          pcw_raw = 1'b1;
          state_d = DECODE;
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      DECODE: begin
        // Branch target PC+imm is captured in the ALU result register here.
        alu_src_b = 2'b10;
        if (opcode == OP_LW || opcode == OP_SW) state_d = EXEC_ADDR;
        else if (opcode == OP_BEQ)               state_d = BRANCH;
        else begin
          state_d   = TRAP;
          illegal_d = 1'b1;
        end
      end
      EXEC_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        req_raw = 1'b1;
        iord    = 1'b1;
        if (mem_ready)    state_d = WB;
        else if (timeout) state_d = TRAP;
      end
      WB: begin
        rw_raw     = 1'b1;
        mem_to_reg = 1'b1;
        retired_d  = retired_q + {{(RET_WIDTH-1){1'b0}}, 1'b1};
        state_d    = FETCH;
      end
      MEM_WR: begin
        req_raw = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          retired_d = retired_q + {{(RET_WIDTH-1){1'b0}}, 1'b1};
          state_d   = FETCH;
        end else if (timeout) begin
          state_d = TRAP;
        end
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pcw_raw   = zero;
        retired_d = retired_q + {{(RET_WIDTH-1){1'b0}}, 1'b1};
        state_d   = FETCH;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // The reset state is FETCH, which requests memory. Gating the strobes
  // with rst_n makes mem_req and the write enables drop as soon as reset
  // is asserted, instead of waiting for a clock edge.
  assign mem_req   = req_raw & rst_n;
  assign ir_write  = irw_raw & rst_n;
  assign pc_write  = pcw_raw & rst_n;
  assign reg_write = rw_raw  & rst_n;
  assign illegal   = illegal_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
module tb_unidade_controle_multiciclo;

  localparam int RW = 4;  // narrow counter so the wrap is reachable

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    opcode = '0;
  logic          zero = 1'b0, mem_ready = 1'b0;
  logic          mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0]    alu_src_b, alu_op;
  logic          reg_write, mem_to_reg, illegal, bus_err;
  logic [RW-1:0] retired;

  int errors = 0;
  int checks = 0;

  unidade_controle_multiciclo #(.MEM_TIMEOUT(15), .RET_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  // {req we iord irw pcw pcsrc srca srcb[1:0] op[1:0] rw m2r ill berr}
  logic [14:0] act;
  assign act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_write, mem_to_reg, illegal, bus_err};

  localparam logic [14:0] V_FW  = 15'b100_000_0_01_00_0000; // fetch waiting
  localparam logic [14:0] V_FR  = 15'b100_110_0_01_00_0000; // fetch ready
  localparam logic [14:0] V_DEC = 15'b000_000_0_10_00_0000;
  localparam logic [14:0] V_EX  = 15'b000_000_1_10_00_0000;
  localparam logic [14:0] V_MRD = 15'b101_000_0_00_00_0000;
  localparam logic [14:0] V_WB  = 15'b000_000_0_00_00_1100;
  localparam logic [14:0] V_MWR = 15'b111_000_0_00_00_0000;
  localparam logic [14:0] V_BT  = 15'b000_011_1_00_01_0000; // beq taken
  localparam logic [14:0] V_BN  = 15'b000_001_1_00_01_0000; // beq not taken
  localparam logic [14:0] V_TRP = 15'b000_000_0_00_00_0010;
  localparam logic [14:0] V_BE  = 15'b000_000_0_00_00_0001;
  localparam logic [14:0] V_RST = 15'b000_000_0_01_00_0000; // FETCH held in reset

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, BEQ = 7'b1100011;
  localparam logic [6:0] RTY = 7'b0110011;

  typedef struct {
    logic [6:0]    op;
    logic          z;
    logic          rdy;
    logic [14:0]   vec;
    logic [RW-1:0] ret;
  } vec_t;

  task automatic chk(input string name, input logic [14:0] v, input logic [RW-1:0] r);
    checks++;
    if (act !== v || retired !== r) begin
      errors++;
      $display("FAIL %s: outputs=%b retired=%0d, expected outputs=%b retired=%0d",
               name, act, retired, v, r);
    end
  endtask

  // Inputs are driven on the falling edge and outputs are checked 1 ns
  // later, well away from the rising edge.
  task automatic step(input string name, input logic [6:0] op, input logic z,
                      input logic rdy, input logic [14:0] v, input logic [RW-1:0] r);
    opcode = op; zero = z; mem_ready = rdy;
    #1 chk(name, v, r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    #1 chk("in_reset", V_RST, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    // lw, zero-wait, with mem_ready high while it must be ignored
    tbl.push_back('{LW, 0, 1, V_FR, 0});
    tbl.push_back('{LW, 0, 1, V_DEC, 0});
    tbl.push_back('{LW, 0, 1, V_EX, 0});
    tbl.push_back('{LW, 0, 1, V_MRD, 0});
    tbl.push_back('{LW, 0, 1, V_WB, 0});
    // sw, ready delayed 3 cycles in MEM_WR
    tbl.push_back('{SW, 0, 1, V_FR, 1});
    tbl.push_back('{SW, 0, 0, V_DEC, 1});
    tbl.push_back('{SW, 0, 0, V_EX, 1});
    tbl.push_back('{SW, 0, 0, V_MWR, 1});
    tbl.push_back('{SW, 0, 0, V_MWR, 1});
    tbl.push_back('{SW, 0, 0, V_MWR, 1});
    tbl.push_back('{SW, 0, 1, V_MWR, 1});
    // beq taken, then not taken
    tbl.push_back('{BEQ, 1, 1, V_FR, 2});
    tbl.push_back('{BEQ, 1, 0, V_DEC, 2});
    tbl.push_back('{BEQ, 1, 1, V_BT, 2});
    tbl.push_back('{BEQ, 0, 1, V_FR, 3});
    tbl.push_back('{BEQ, 0, 0, V_DEC, 3});
    tbl.push_back('{BEQ, 0, 0, V_BN, 3});
    // lw with fetch and read wait states
    tbl.push_back('{LW, 0, 0, V_FW, 4});
    tbl.push_back('{LW, 0, 0, V_FW, 4});
    tbl.push_back('{LW, 0, 1, V_FR, 4});
    tbl.push_back('{LW, 0, 1, V_DEC, 4});
    tbl.push_back('{LW, 0, 0, V_EX, 4});
    tbl.push_back('{LW, 0, 0, V_MRD, 4});
    tbl.push_back('{LW, 0, 1, V_MRD, 4});
    tbl.push_back('{LW, 0, 0, V_WB, 4});
    // unsupported opcode traps
    tbl.push_back('{RTY, 0, 1, V_FR, 5});
    tbl.push_back('{RTY, 0, 1, V_DEC, 5});

    do_reset();
    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i].op, tbl[i].z, tbl[i].rdy, tbl[i].vec, tbl[i].ret);

    // TRAP holds for 20 cycles with no requests and no retirement
    for (int i = 0; i < 20; i++)
      step($sformatf("trap%0d", i), SW, 1'b0, 1'b1, V_TRP, 4'd5);

    do_reset();
    step("after_trap_reset", LW, 1'b0, 1'b0, V_FW, 4'd0);

    // Reset asserted while waiting in MEM_RD: mem_req drops without a clock
    step("r_f", LW, 1'b0, 1'b1, V_FR, 4'd0);
    step("r_d", LW, 1'b0, 1'b0, V_DEC, 4'd0);
    step("r_e", LW, 1'b0, 1'b0, V_EX, 4'd0);
    step("r_m", LW, 1'b0, 1'b0, V_MRD, 4'd0);
    #2 rst_n = 1'b0;
    #1 chk("async_drop", V_RST, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("after_mid_reset", LW, 1'b0, 1'b0, V_FW, 4'd0);

    // retired wraps 15 -> 0 after 16 beq instructions
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step($sformatf("wrap_f%0d", i), BEQ, 1'b0, 1'b1, V_FR, RW'(i));
      step($sformatf("wrap_d%0d", i), BEQ, 1'b0, 1'b0, V_DEC, RW'(i));
      step($sformatf("wrap_b%0d", i), BEQ, 1'b0, 1'b0, V_BN, RW'(i));
    end
    step("wrapped", BEQ, 1'b0, 1'b0, V_FW, 4'd0);

`ifdef MEM_TIMEOUT_EN
    // 15 cycles with no mem_ready in FETCH lead to a bus-error trap
    do_reset();
    for (int i = 0; i < 15; i++)
      step($sformatf("to_w%0d", i), LW, 1'b0, 1'b0, V_FW, 4'd0);
    step("to_trap", LW, 1'b0, 1'b1, V_BE, 4'd0);
    step("to_trap_hold", LW, 1'b0, 1'b1, V_BE, 4'd0);
    // mem_ready on the 15th wait cycle completes the fetch normally
    do_reset();
    for (int i = 0; i < 14; i++)
      step($sformatf("ok_w%0d", i), LW, 1'b0, 1'b0, V_FW, 4'd0);
    step("ok_rdy", LW, 1'b0, 1'b1, V_FR, 4'd0);
    step("ok_dec", LW, 1'b0, 1'b0, V_DEC, 4'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
